count_bcd_decoder: RTL and testbench

Downstream stage of the 8-bit up/down modulus-range counter (range MIN..MAX, default 10..40). It watches the counter's `count` bus and converts each new value to three BCD digits with a sequential shift-and-add-3 (double-dabble) engine. It also flags range wrap-arounds and out-of-range values. Its outputs feed the display/readout logic.

---
 rtl/count_bcd_decoder_if.sv | 22 ++
 rtl/count_bcd_decoder.sv | 127 ++++++++++++
 tb/tb_count_bcd_decoder.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/count_bcd_decoder_if.sv
// Bundle of the counter value into the decoder and the digit/flag outputs back to the readout logic.
interface count_bcd_decoder_if;
  logic [7:0] count;
  logic [1:0] hundreds;
  logic [3:0] tens;
  logic [3:0] units;
  logic       valid;
  logic       busy;
  logic       wrap_up;
  logic       wrap_dn;
  logic       out_of_range;

  modport master (
    output count,
    input  hundreds, tens, units, valid, busy, wrap_up, wrap_dn, out_of_range
  );

  modport slave (
    input  count,
    output hundreds, tens, units, valid, busy, wrap_up, wrap_dn, out_of_range
  );
endinterface

// File: rtl/count_bcd_decoder.sv
// Converts each new counter value to three BCD digits with a bit-serial double-dabble engine,
// and flags range wrap-arounds and out-of-range values every cycle.
module count_bcd_decoder #(
  parameter int           WIDTH = 8,
  parameter logic [7:0]   MIN   = 8'd10,
  parameter logic [7:0]   MAX   = 8'd40
) (
  input  logic                clk,
  input  logic                rst,
  count_bcd_decoder_if.slave  bus
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   shift_reg, shift_next;
  logic [WIDTH-1:0]   last_reg, last_next;
  logic [9:0]         bcd_reg, bcd_next;
  logic [2:0]         bit_cnt_reg, bit_cnt_next;
  logic               first_reg, first_next;
  logic [1:0]         hundreds_reg, hundreds_next;
  logic [3:0]         tens_reg, tens_next;
  logic [3:0]         units_reg, units_next;
  logic               valid_reg, valid_next;
  logic [WIDTH-1:0]   count_d_reg;
  logic               wrap_up_reg, wrap_dn_reg, oor_reg;
  logic [9:0]         adj;

  // Hundreds never exceeds 1 before the final shift, so only the two low nibbles need the add-3 step.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_adj
      assign adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ? bcd_reg[gi*4 +: 4] + 4'd3
                                                            : bcd_reg[gi*4 +: 4];
    end
  endgenerate
  assign adj[9:8] = bcd_reg[9:8];

  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    last_next     = last_reg;
    bcd_next      = bcd_reg;
    bit_cnt_next  = bit_cnt_reg;
    first_next    = first_reg;
    hundreds_next = hundreds_reg;
    tens_next     = tens_reg;
    units_next    = units_reg;
    valid_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (first_reg || (bus.count != last_reg)) begin
          shift_next   = bus.count;
          last_next    = bus.count;
          bcd_next     = '0;
          bit_cnt_next = '0;
          first_next   = 1'b0;
          state_next   = SHIFT;
        end
      end
      SHIFT: begin
        bcd_next     = {adj[8:0], shift_reg[WIDTH-1]};
        shift_next   = {shift_reg[WIDTH-2:0], 1'b0};
        bit_cnt_next = bit_cnt_reg + 3'd1;
        if (bit_cnt_reg == 3'd7) begin
          hundreds_next = bcd_next[9:8];
          tens_next     = bcd_next[7:4];
          units_next    = bcd_next[3:0];
          valid_next    = 1'b1;
          state_next    = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      last_reg     <= '0;
      bcd_reg      <= '0;
      bit_cnt_reg  <= '0;
      first_reg    <= 1'b1;
      hundreds_reg <= '0;
      tens_reg     <= '0;
      units_reg    <= '0;
      valid_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      last_reg     <= last_next;
      bcd_reg      <= bcd_next;
      bit_cnt_reg  <= bit_cnt_next;
      first_reg    <= first_next;
      hundreds_reg <= hundreds_next;
      tens_reg     <= tens_next;
      units_reg    <= units_next;
      valid_reg    <= valid_next;
    end
  end

  // Flag logic watches the raw bus every cycle, independent of the conversion engine.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_d_reg <= '0;
      wrap_up_reg <= 1'b0;
      wrap_dn_reg <= 1'b0;
      oor_reg     <= 1'b0;
    end else begin
      count_d_reg <= bus.count;
      wrap_up_reg <= (count_d_reg == MAX) && (bus.count == MIN);
      wrap_dn_reg <= (count_d_reg == MIN) && (bus.count == MAX);
      oor_reg     <= (bus.count < MIN) || (bus.count > MAX);
    end
  end

  assign bus.hundreds     = hundreds_reg;
  assign bus.tens         = tens_reg;
  assign bus.units        = units_reg;
  assign bus.valid        = valid_reg;
  assign bus.busy         = (state_reg == SHIFT);
  assign bus.wrap_up      = wrap_up_reg;
  assign bus.wrap_dn      = wrap_dn_reg;
  assign bus.out_of_range = oor_reg;

endmodule

// File: tb/tb_count_bcd_decoder.sv
// Self-checking bench: digit table plus hand sequences for reset, mid-conversion changes and reset abort.
module tb_count_bcd_decoder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  count_bcd_decoder_if bus_if ();

  count_bcd_decoder #(.WIDTH(8), .MIN(8'd10), .MAX(8'd40)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  typedef struct {
    logic [7:0] count;
    int         h, t, u;
    bit         oor, wu, wd;
  } vec_t;

  vec_t tbl[12];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_q[$];
  int   valid_cnt = 0;
  int   wu_cnt = 0;
  int   wd_cnt = 0;
  int   busy_run = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int dig(input int h, input int t, input int u);
    return h * 256 + t * 16 + u;
  endfunction

  // Monitor: pops the scoreboard on every valid and checks the busy window length.
  always @(negedge clk) begin
    if (!rst) begin
      busy_run = 0;
    end else begin
      if (bus_if.wrap_up) wu_cnt++;
      if (bus_if.wrap_dn) wd_cnt++;
      if (bus_if.valid) begin
        valid_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          check("sb_digits", dig(int'(bus_if.hundreds), int'(bus_if.tens), int'(bus_if.units)),
                exp_q.pop_front());
        end
        check("busy_cycles", busy_run, 8);
        busy_run = 0;
      end else if (bus_if.busy) begin
        busy_run++;
      end
    end
  end

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic check_all_zero(input string name);
    check(name, int'({bus_if.hundreds, bus_if.tens, bus_if.units, bus_if.valid, bus_if.busy,
                      bus_if.wrap_up, bus_if.wrap_dn, bus_if.out_of_range}), 0);
  endtask

  task automatic apply_vec(input vec_t v);
    int wu0, wd0, vc0;
    bus_if.count = v.count;
    exp_q.push_back(dig(v.h, v.t, v.u));
    wu0 = wu_cnt; wd0 = wd_cnt; vc0 = valid_cnt;
    @(negedge clk);
    check("out_of_range", int'(bus_if.out_of_range), int'(v.oor));
    check("wrap_up_now", int'(bus_if.wrap_up), int'(v.wu));
    check("wrap_dn_now", int'(bus_if.wrap_dn), int'(v.wd));
    wait_cycles(11);
    check("digits_held", dig(int'(bus_if.hundreds), int'(bus_if.tens), int'(bus_if.units)),
          dig(v.h, v.t, v.u));
    check("valid_per_value", valid_cnt - vc0, 1);
    check("wrap_up_pulses", wu_cnt - wu0, int'(v.wu));
    check("wrap_dn_pulses", wd_cnt - wd0, int'(v.wd));
    $display("vec count=%0d -> %0d/%0d/%0d oor=%0d", v.count, bus_if.hundreds, bus_if.tens,
             bus_if.units, bus_if.out_of_range);
  endtask

  initial begin
    int vc0, wu0, wd0;
    tbl[0]  = '{8'd39,  0, 3, 9, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{8'd40,  0, 4, 0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{8'd255, 2, 5, 5, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{8'd39,  0, 3, 9, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{8'd40,  0, 4, 0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{8'd10,  0, 1, 0, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{8'd11,  0, 1, 1, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{8'd10,  0, 1, 0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{8'd40,  0, 4, 0, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{8'd5,   0, 0, 5, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{8'd41,  0, 4, 1, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{8'd40,  0, 4, 0, 1'b0, 1'b0, 1'b0};

    // Reset state and forced first conversion of an unchanging value.
    bus_if.count = 8'd10;
    wait_cycles(3);
    check_all_zero("reset_outputs");
    exp_q.push_back(dig(0, 1, 0));
    rst = 1'b1;
    wait_cycles(12);
    check("forced_valid_count", valid_cnt, 1);
    check("forced_digits", dig(int'(bus_if.hundreds), int'(bus_if.tens), int'(bus_if.units)),
          dig(0, 1, 0));
    $display("forced conversion count=10 -> %0d/%0d/%0d", bus_if.hundreds, bus_if.tens, bus_if.units);

    foreach (tbl[i]) apply_vec(tbl[i]);

    // Stepping count during a conversion: only 11 and the final 20 come out.
    wu0 = wu_cnt; wd0 = wd_cnt;
    bus_if.count = 8'd25; exp_q.push_back(dig(0, 2, 5)); wait_cycles(12);
    bus_if.count = 8'd10; exp_q.push_back(dig(0, 1, 0)); wait_cycles(12);
    vc0 = valid_cnt;
    exp_q.push_back(dig(0, 1, 1));
    exp_q.push_back(dig(0, 2, 0));
    for (int c = 11; c <= 20; c++) begin
      bus_if.count = 8'(c);
      @(negedge clk);
    end
    wait_cycles(20);
    check("step_valid_count", valid_cnt - vc0, 2);
    check("step_final", dig(int'(bus_if.hundreds), int'(bus_if.tens), int'(bus_if.units)),
          dig(0, 2, 0));
    check("step_no_wraps", (wu_cnt - wu0) + (wd_cnt - wd0), 0);
    $display("step 11..20 -> %0d/%0d/%0d", bus_if.hundreds, bus_if.tens, bus_if.units);

    // Reset four cycles into a conversion of 25: partial result discarded.
    vc0 = valid_cnt;
    bus_if.count = 8'd25;
    wait_cycles(5);
    check("abort_busy_before", int'(bus_if.busy), 1);
    rst = 1'b0;
    #1;
    check_all_zero("abort_outputs");
    wait_cycles(2);
    check("abort_no_valid", valid_cnt - vc0, 0);
    exp_q.push_back(dig(0, 2, 5));
    rst = 1'b1;
    wait_cycles(8);
    check("abort_not_yet", int'(bus_if.valid), 0);
    @(negedge clk);
    check("abort_valid_at_c8", int'(bus_if.valid), 1);
    check("abort_digits", dig(int'(bus_if.hundreds), int'(bus_if.tens), int'(bus_if.units)),
          dig(0, 2, 5));
    wait_cycles(3);
    check("abort_valid_count", valid_cnt - vc0, 1);
    $display("reset abort then reconvert 25 -> %0d/%0d/%0d", bus_if.hundreds, bus_if.tens, bus_if.units);

    check("wrap_up_total", wu_cnt, 1);
    check("wrap_dn_total", wd_cnt, 1);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
